// File: rtl/title_screen_mixer.sv
// Title screen mixer: aligns DTG timing with the title RAM read latency,
// runs the title / fade / game screen sequencer, and drives the registered
// 12-bit RGB and sync outputs to the VGA connector.
module title_screen_mixer #(
  parameter int PIPE_DELAY           = 1,
  parameter int FADE_FRAMES_PER_STEP = 4,
  parameter int BLINK_FRAMES         = 32,
  parameter int PROMPT_Y0            = 128,
  parameter int PROMPT_Y1            = 159
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [31:0] pixel_row,
  input  logic               video_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [11:0]        title_color,
  input  logic [11:0]        game_color,
  input  logic               start_pulse,
  input  logic               game_over_pulse,
  output logic [11:0]        vga_rgb,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               title_active,
  output logic               in_game
);

  // Counter widths; a divide-by-one fade still needs a 1-bit register.
  localparam int FDW = (FADE_FRAMES_PER_STEP > 1) ? $clog2(FADE_FRAMES_PER_STEP) : 1;
  localparam int BCW = $clog2(BLINK_FRAMES);
  localparam logic [FDW-1:0] FD_LAST = FDW'(FADE_FRAMES_PER_STEP - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_TITLE = 2'd0,
    ST_FADE  = 2'd1,
    ST_GAME  = 2'd2
  } state_t;

  // Per-channel subtract that floors at zero instead of wrapping.
  function automatic logic [3:0] sat_sub4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    if (a > b) begin
      r = a - b;
    end else begin
      r = 4'd0;
    end
    return r;
  endfunction

  // Darken all three channels of a colour by the current fade level.
  function automatic logic [11:0] fade_color(input logic [11:0] c, input logic [3:0] lvl);
    return {sat_sub4(c[11:8], lvl), sat_sub4(c[7:4], lvl), sat_sub4(c[3:0], lvl)};
  endfunction

  // ---------------------------------------------------------------------
  // DTG alignment delay line
  // ---------------------------------------------------------------------
  logic        vid_pipe    [PIPE_DELAY];
  logic        hs_pipe     [PIPE_DELAY];
  logic        vs_pipe     [PIPE_DELAY];
  logic        prompt_pipe [PIPE_DELAY];
  logic [11:0] game_pipe   [PIPE_DELAY];

  logic        in_prompt;
  logic        d_video;
  logic        d_hsync;
  logic        d_vsync;
  logic        d_prompt;
  logic [11:0] d_game;

  assign in_prompt = (pixel_row >= PROMPT_Y0) && (pixel_row <= PROMPT_Y1);

  // Shift DTG-side signals so they line up with the title RAM output.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        vid_pipe[i]    <= 1'b0;
        hs_pipe[i]     <= 1'b1;
        vs_pipe[i]     <= 1'b1;
        prompt_pipe[i] <= 1'b0;
        game_pipe[i]   <= 12'h000;
      end
    end else begin
      vid_pipe[0]    <= video_on;
      hs_pipe[0]     <= hsync_in;
      vs_pipe[0]     <= vsync_in;
      prompt_pipe[0] <= in_prompt;
      game_pipe[0]   <= game_color;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        vid_pipe[i]    <= vid_pipe[i-1];
        hs_pipe[i]     <= hs_pipe[i-1];
        vs_pipe[i]     <= vs_pipe[i-1];
        prompt_pipe[i] <= prompt_pipe[i-1];
        game_pipe[i]   <= game_pipe[i-1];
      end
    end
  end

  assign d_video  = vid_pipe[PIPE_DELAY-1];
  assign d_hsync  = hs_pipe[PIPE_DELAY-1];
  assign d_vsync  = vs_pipe[PIPE_DELAY-1];
  assign d_prompt = prompt_pipe[PIPE_DELAY-1];
  assign d_game   = game_pipe[PIPE_DELAY-1];

  // ---------------------------------------------------------------------
  // Frame tick on the falling edge of the aligned vsync
  // ---------------------------------------------------------------------
  logic vsync_prev;
  logic frame_tick;

  // Remember last aligned vsync; idles high so reset never fakes a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_prev <= 1'b1;
    end else begin
      vsync_prev <= d_vsync;
    end
  end

  assign frame_tick = vsync_prev & ~d_vsync;

  // ---------------------------------------------------------------------
  // Screen sequencer
  // ---------------------------------------------------------------------
  state_t         state;
  state_t         state_next;
  logic [3:0]     fade_level;
  logic [3:0]     fade_next;
  logic [FDW-1:0] frame_div;
  logic [FDW-1:0] div_next;
  logic [BCW-1:0] blink_cnt;
  logic [BCW-1:0] blink_next;
  logic           blink_phase;
  logic           phase_next;

  // Sequencer state and frame counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_TITLE;
      fade_level  <= 4'd0;
      frame_div   <= {FDW{1'b0}};
      blink_cnt   <= {BCW{1'b0}};
      blink_phase <= 1'b0;
    end else begin
      state       <= state_next;
      fade_level  <= fade_next;
      frame_div   <= div_next;
      blink_cnt   <= blink_next;
      blink_phase <= phase_next;
    end
  end

  // Next-state and counter update; counters only move on a frame tick.
  always_comb begin
    state_next = state;
    fade_next  = fade_level;
    div_next   = frame_div;
    blink_next = blink_cnt;
    phase_next = blink_phase;
    case (state)
      ST_TITLE: begin
        if (frame_tick) begin
          if (blink_cnt == BC_LAST) begin
            blink_next = {BCW{1'b0}};
            phase_next = ~blink_phase;
          end else begin
            blink_next = blink_cnt + {{(BCW-1){1'b0}}, 1'b1};
          end
        end else begin
          blink_next = blink_cnt;
        end
        // Start beats a coincident game-over; game-over alone is ignored here.
        if (start_pulse) begin
          state_next = ST_FADE;
          fade_next  = 4'd0;
          div_next   = {FDW{1'b0}};
        end else begin
          state_next = ST_TITLE;
        end
      end
      ST_FADE: begin
        if (frame_tick) begin
          if (frame_div == FD_LAST) begin
            div_next = {FDW{1'b0}};
            // The last step at full darkness hands over to the game and
            // leaves the level pinned at 15.
            if (fade_level == 4'd15) begin
              state_next = ST_GAME;
            end else begin
              fade_next = fade_level + 4'd1;
            end
          end else begin
            div_next = frame_div + {{(FDW-1){1'b0}}, 1'b1};
          end
        end else begin
          div_next = frame_div;
        end
      end
      ST_GAME: begin
        if (game_over_pulse) begin
          state_next = ST_TITLE;
          blink_next = {BCW{1'b0}};
          phase_next = 1'b0;
          fade_next  = 4'd0;
        end else begin
          state_next = ST_GAME;
        end
      end
      default: begin
        state_next = ST_TITLE;
        fade_next  = 4'd0;
        div_next   = {FDW{1'b0}};
        blink_next = {BCW{1'b0}};
        phase_next = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Colour selection and output registers
  // ---------------------------------------------------------------------
  logic [11:0] rgb_next;

  // Pick the pixel colour for the state this pixel is rendered in.
  always_comb begin
    rgb_next = 12'h000;
    if (!d_video) begin
      rgb_next = 12'h000;
    end else begin
      case (state_next)
        ST_TITLE: begin
          if (d_prompt && phase_next) begin
            rgb_next = 12'h000;
          end else begin
            rgb_next = title_color;
          end
        end
        ST_FADE:  rgb_next = fade_color(title_color, fade_next);
        ST_GAME:  rgb_next = d_game;
        default:  rgb_next = 12'h000;
      endcase
    end
  end

  // Registered VGA pins and status flags; syncs are never gated by state.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_rgb      <= 12'h000;
      vga_hsync    <= 1'b1;
      vga_vsync    <= 1'b1;
      title_active <= 1'b1;
      in_game      <= 1'b0;
    end else begin
      vga_rgb      <= rgb_next;
      vga_hsync    <= d_hsync;
      vga_vsync    <= d_vsync;
      title_active <= (state_next == ST_TITLE) || (state_next == ST_FADE);
      in_game      <= (state_next == ST_GAME);
    end
  end

endmodule
